rv_decode_execute: RTL and testbench
====================================

// Module: rv_decode_execute
// PURPOSE
//  RV32I decode+execute slice: control decode of one instruction, ALU and branch-condition unit.
//  Sits between the ID/EX operand path (forwarded rs1/rs2, external immediate generator) and the MEM stage.
//  Results are registered once; reset is synchronous, active-high.
// PARAMETERS
//  XLEN  32  datapath width (only 32 supported)
// PORTS
//  clk               in   1     clock, all state on rising edge
//  rst               in   1     synchronous active-high reset
//  inst_i            in   32    instruction word
//  pc_i              in   32    PC of inst_i
//  rs1_data_i        in   32    forwarded rs1 value
//  rs2_data_i        in   32    forwarded rs2 value
//  imm_i             in   32    sign-extended immediate from external imm generator
//  imm_src_o         out  3     COMBINATIONAL: 000 I, 001 S, 010 B, 011 U, 100 J (drives imm generator)
//  alu_res_o         out  32    registered ALU result (branch/jump target for B/J/JALR)
//  next_pc_src_o     out  1     registered: 1 = redirect PC to alu_res_o
//  ru_wr_o           out  1     registered register-file write enable
//  dm_wr_o / dm_rd_o out  1     registered data-memory write / read
//  dm_ctrl_o         out  3     registered = funct3 (access size/sign)
//  ru_data_wr_src_o  out  2     registered writeback source: 00 ALU, 01 DMEM, 10 PC+4
// BEHAVIOUR
//  Latency 1: combinational decode/ALU/branch sampled at each rising clk; no stall/handshake.
//  rst=1 at an edge: every registered output <= 0 (inert NOP); imm_src_o stays combinational.
//  Decode (opcode inst[6:0]; ASrc 1=PC; BSrc 1=imm; ALUOp; BrOp; wb):
//   0110011 R:     RUWr, A=rs1,B=rs2, ALUOp={f7[5],f3}, wb 00
//   0010011 I-ALU: RUWr, B=imm, ALUOp={f3==101?f7[5]:0, f3}, ImmSrc I
//   0000011 LOAD:  RUWr, DMRd, B=imm, ADD, wb 01, ImmSrc I
//   0100011 STORE: DMWr, B=imm, ADD, ImmSrc S
//   1100011 BR:    A=PC,B=imm, ADD, BrOp={2'b01,f3}, ImmSrc B
//   1101111 JAL:   RUWr, A=PC,B=imm, ADD, BrOp=1xxxx, wb 10, ImmSrc J
//   1100111 JALR:  RUWr, A=rs1,B=imm, ADD, BrOp=1xxxx, wb 10, ImmSrc I
//   0110111 LUI:   RUWr, B=imm, ALUOp 1001 (pass B), ImmSrc U
//   0010111 AUIPC: RUWr, A=PC,B=imm, ADD, ImmSrc U
//   other opcode:  RUWr=DMWr=DMRd=0, BrOp=00000, ALUOp ADD.
//  ALUOp: 0000 add, 1000 sub, 0001 sll, 0010 slt(signed), 0011 sltu, 0100 xor, 0101 srl,
//   1101 sra, 0110 or, 0111 and, 1001 pass B; unlisted -> 0. Shifts use B[4:0]; add/sub wrap mod 2^32.
//  Branch unit compares rs1_data_i vs rs2_data_i (never imm/PC): BrOp[4]=1 -> taken;
//   BrOp[4:3]=01 -> f3 000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu, 010/011 not taken;
//   BrOp[4:3]=00 -> not taken.
//  dm_ctrl_o = funct3 for every opcode; write enables alone qualify its use.
// STRUCTURE
//  Package rv_pkg: opcode constants, alu_op_e (4b), BrOp field layout, imm_src_e, wb_src_e.
//  One sub-module exec_alu (combinational A,B,ALUOp -> S); decoder and branch compare inline.
// TESTING
//  rst=1 one edge with ADD inst -> all registered outputs 0; deassert -> normal results next edge.
//  R SUB (inst 0x40208033) rs1=5, rs2=7 -> alu_res 0xFFFFFFFE, ru_wr 1, wb 00, next_pc_src 0.
//  SRAI x1,x2,4 (0x40415093) rs1=0x80000000, imm=0x404 -> alu_res 0xF8000000; SLT -1<1 -> 1, SLTU -> 0.
//  BEQ pc=0x100 imm=8, rs1=rs2=3 -> next_pc_src 1, alu_res 0x108; rs2=4 -> next_pc_src 0.
//  BLTU 0xFFFFFFFF vs 1 -> not taken; BLT same -> taken; JAL pc=0x20 imm=0x10 -> taken, 0x30, wb 10.
//  LW -> dm_rd 1, ru_wr 1, wb 01; SW -> dm_wr 1, ru_wr 0; LUI imm=0x12345000 -> 0x12345000; opcode 0 -> inert.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared types for the RV32I decode/execute slice: opcodes, ALU ops,
// branch-op layout, immediate selector and writeback source.
package rv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b1000,
    ALU_SLL   = 4'b0001,
    ALU_SLT   = 4'b0010,
    ALU_SLTU  = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SRL   = 4'b0101,
    ALU_SRA   = 4'b1101,
    ALU_OR    = 4'b0110,
    ALU_AND   = 4'b0111,
    ALU_PASSB = 4'b1001
  } alu_op_e;

  // jump=1 forces taken; cond=1 evaluates f3 against rs1/rs2.
  typedef struct packed {
    logic       jump;
    logic       cond;
    logic [2:0] f3;
  } br_op_t;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_DMEM = 2'b01,
    WB_PC4  = 2'b10
  } wb_src_e;

  typedef struct packed {
    logic     a_pc;
    logic     b_imm;
    alu_op_e  alu_op;
    br_op_t   br_op;
    logic     ru_wr;
    logic     dm_wr;
    logic     dm_rd;
    wb_src_e  wb_src;
    imm_src_e imm_src;
  } ctrl_t;

endpackage

// File: rtl/exec_alu.sv
// Combinational RV32I ALU; unlisted op codes yield zero.
module exec_alu
  import rv_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_e         op,
  output logic [XLEN-1:0] s
);

  always_comb begin
    s = '0;
    case (op)
      ALU_ADD:   s = a + b;
      ALU_SUB:   s = a - b;
      ALU_SLL:   s = a << b[4:0];
      ALU_SLT:   s = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU:  s = {{(XLEN-1){1'b0}}, a < b};
      ALU_XOR:   s = a ^ b;
      ALU_SRL:   s = a >> b[4:0];
      ALU_SRA:   s = XLEN'($signed(a) >>> b[4:0]);
      ALU_OR:    s = a | b;
      ALU_AND:   s = a & b;
      ALU_PASSB: s = b;
      default:   s = '0;
    endcase
  end

endmodule

// File: rtl/rv_decode_execute.sv
// RV32I decode + execute slice: control decode, ALU and branch compare,
// results registered once toward the MEM stage.
module rv_decode_execute
  import rv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] inst_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [XLEN-1:0] imm_i,
  output logic [2:0]      imm_src_o,
  output logic [XLEN-1:0] alu_res_o,
  output logic            next_pc_src_o,
  output logic            ru_wr_o,
  output logic            dm_wr_o,
  output logic            dm_rd_o,
  output logic [2:0]      dm_ctrl_o,
  output logic [1:0]      ru_data_wr_src_o
);

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic            f7_5;
  ctrl_t           ctrl;
  logic [XLEN-1:0] alu_a, alu_b, alu_s;
  logic            br_taken;
  logic            unused_inst;

  assign opcode      = inst_i[6:0];
  assign f3          = inst_i[14:12];
  assign f7_5        = inst_i[30];
  assign unused_inst = ^{inst_i[31], inst_i[29:15], inst_i[11:7]};

  always_comb begin
    ctrl = '{a_pc: 1'b0, b_imm: 1'b0, alu_op: ALU_ADD, br_op: '0,
             ru_wr: 1'b0, dm_wr: 1'b0, dm_rd: 1'b0, wb_src: WB_ALU, imm_src: IMM_I};
    case (opcode)
      OP_R: begin
        ctrl.ru_wr  = 1'b1;
        ctrl.alu_op = alu_op_e'({f7_5, f3});
      end
      OP_I_ALU: begin
        ctrl.ru_wr  = 1'b1;
        ctrl.b_imm  = 1'b1;
        // f7[5] only distinguishes SRAI from SRLI; elsewhere it is immediate bits.
        ctrl.alu_op = alu_op_e'({(f3 == 3'b101) ? f7_5 : 1'b0, f3});
      end
      OP_LOAD: begin
        ctrl.ru_wr  = 1'b1;
        ctrl.dm_rd  = 1'b1;
        ctrl.b_imm  = 1'b1;
        ctrl.wb_src = WB_DMEM;
      end
      OP_STORE: begin
        ctrl.dm_wr   = 1'b1;
        ctrl.b_imm   = 1'b1;
        ctrl.imm_src = IMM_S;
      end
      OP_BRANCH: begin
        ctrl.a_pc    = 1'b1;
        ctrl.b_imm   = 1'b1;
        ctrl.br_op   = '{jump: 1'b0, cond: 1'b1, f3: f3};
        ctrl.imm_src = IMM_B;
      end
      OP_JAL: begin
        ctrl.ru_wr   = 1'b1;
        ctrl.a_pc    = 1'b1;
        ctrl.b_imm   = 1'b1;
        ctrl.br_op   = '{jump: 1'b1, cond: 1'b0, f3: f3};
        ctrl.wb_src  = WB_PC4;
        ctrl.imm_src = IMM_J;
      end
      OP_JALR: begin
        ctrl.ru_wr  = 1'b1;
        ctrl.b_imm  = 1'b1;
        ctrl.br_op  = '{jump: 1'b1, cond: 1'b0, f3: f3};
        ctrl.wb_src = WB_PC4;
      end
      OP_LUI: begin
        ctrl.ru_wr   = 1'b1;
        ctrl.b_imm   = 1'b1;
        ctrl.alu_op  = ALU_PASSB;
        ctrl.imm_src = IMM_U;
      end
      OP_AUIPC: begin
        ctrl.ru_wr   = 1'b1;
        ctrl.a_pc    = 1'b1;
        ctrl.b_imm   = 1'b1;
        ctrl.imm_src = IMM_U;
      end
      default: ;
    endcase
  end

  assign imm_src_o = ctrl.imm_src;
  assign alu_a     = ctrl.a_pc  ? pc_i  : rs1_data_i;
  assign alu_b     = ctrl.b_imm ? imm_i : rs2_data_i;

  exec_alu u_alu (
    .a  (alu_a),
    .b  (alu_b),
    .op (ctrl.alu_op),
    .s  (alu_s)
  );

  // Condition always compares the forwarded registers, never the ALU operands.
  always_comb begin
    br_taken = 1'b0;
    if (ctrl.br_op.jump) br_taken = 1'b1;
    else if (ctrl.br_op.cond) begin
      case (ctrl.br_op.f3)
        3'b000:  br_taken = (rs1_data_i == rs2_data_i);
        3'b001:  br_taken = (rs1_data_i != rs2_data_i);
        3'b100:  br_taken = ($signed(rs1_data_i) <  $signed(rs2_data_i));
        3'b101:  br_taken = ($signed(rs1_data_i) >= $signed(rs2_data_i));
        3'b110:  br_taken = (rs1_data_i <  rs2_data_i);
        3'b111:  br_taken = (rs1_data_i >= rs2_data_i);
        default: br_taken = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_res_o        <= '0;
      next_pc_src_o    <= 1'b0;
      ru_wr_o          <= 1'b0;
      dm_wr_o          <= 1'b0;
      dm_rd_o          <= 1'b0;
      dm_ctrl_o        <= '0;
      ru_data_wr_src_o <= '0;
    end else begin
      alu_res_o        <= alu_s;
      next_pc_src_o    <= br_taken;
      ru_wr_o          <= ctrl.ru_wr;
      dm_wr_o          <= ctrl.dm_wr;
      dm_rd_o          <= ctrl.dm_rd;
      dm_ctrl_o        <= f3;
      ru_data_wr_src_o <= ctrl.wb_src;
    end
  end

endmodule

// File: tb/tb_rv_decode_execute.sv
// Directed self-checking bench for rv_decode_execute.
module tb_rv_decode_execute;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_i, pc_i, rs1_data_i, rs2_data_i, imm_i;
  logic [2:0]  imm_src_o;
  logic [31:0] alu_res_o;
  logic        next_pc_src_o, ru_wr_o, dm_wr_o, dm_rd_o;
  logic [2:0]  dm_ctrl_o;
  logic [1:0]  ru_data_wr_src_o;

  int checks = 0;
  int failures = 0;

  rv_decode_execute dut (
    .clk              (clk),
    .rst              (rst),
    .inst_i           (inst_i),
    .pc_i             (pc_i),
    .rs1_data_i       (rs1_data_i),
    .rs2_data_i       (rs2_data_i),
    .imm_i            (imm_i),
    .imm_src_o        (imm_src_o),
    .alu_res_o        (alu_res_o),
    .next_pc_src_o    (next_pc_src_o),
    .ru_wr_o          (ru_wr_o),
    .dm_wr_o          (dm_wr_o),
    .dm_rd_o          (dm_rd_o),
    .dm_ctrl_o        (dm_ctrl_o),
    .ru_data_wr_src_o (ru_data_wr_src_o)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] imm);
    @(negedge clk);
    inst_i = inst; pc_i = pc; rs1_data_i = r1; rs2_data_i = r2; imm_i = imm;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(32'h0020_8033, 32'h40, 32'd1, 32'd2, 32'd0);
    tick();
    checks++; if ({alu_res_o, next_pc_src_o, ru_wr_o, dm_wr_o, dm_rd_o, dm_ctrl_o, ru_data_wr_src_o} !== 42'd0) begin
      failures++; $display("FAIL reset_outputs got res=%h npc=%b ru=%b dw=%b dr=%b ctl=%b wb=%b exp all 0",
        alu_res_o, next_pc_src_o, ru_wr_o, dm_wr_o, dm_rd_o, dm_ctrl_o, ru_data_wr_src_o); end
    rst = 1'b0;
    tick();
    checks++; if (alu_res_o !== 32'd3 || ru_wr_o !== 1'b1) begin
      failures++; $display("FAIL post_reset_add got res=%h ru=%b exp 00000003 1", alu_res_o, ru_wr_o); end
  endtask

  task automatic test_r_alu();
    drive(32'h4020_8033, 32'h0, 32'd5, 32'd7, 32'hDEAD);
    tick();
    checks++; if (alu_res_o !== 32'hFFFF_FFFE) begin
      failures++; $display("FAIL r_sub got=%h exp=FFFFFFFE", alu_res_o); end
    checks++; if (ru_wr_o !== 1'b1 || ru_data_wr_src_o !== 2'b00 || next_pc_src_o !== 1'b0) begin
      failures++; $display("FAIL r_sub_ctrl got ru=%b wb=%b npc=%b exp 1 00 0", ru_wr_o, ru_data_wr_src_o, next_pc_src_o); end
    drive(32'h0020_A033, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h0);
    tick();
    checks++; if (alu_res_o !== 32'd1) begin
      failures++; $display("FAIL r_slt got=%h exp=00000001", alu_res_o); end
    drive(32'h0020_B033, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'h0);
    tick();
    checks++; if (alu_res_o !== 32'd0) begin
      failures++; $display("FAIL r_sltu got=%h exp=00000000", alu_res_o); end
    drive(32'h0020_F033, 32'h0, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h0);
    tick();
    checks++; if (alu_res_o !== 32'h00F0_F000) begin
      failures++; $display("FAIL r_and got=%h exp=00F0F000", alu_res_o); end
    drive(32'h0020_C033, 32'h0, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h0);
    tick();
    checks++; if (alu_res_o !== 32'hFF00_0FF0) begin
      failures++; $display("FAIL r_xor got=%h exp=FF000FF0", alu_res_o); end
    drive(32'h0020_9033, 32'h0, 32'h0000_0003, 32'h0000_0024, 32'h0);
    tick();
    checks++; if (alu_res_o !== 32'h0000_0030) begin
      failures++; $display("FAIL r_sll_b4_0 got=%h exp=00000030", alu_res_o); end
  endtask

  task automatic test_i_alu();
    drive(32'h4041_5093, 32'h0, 32'h8000_0000, 32'h0, 32'h0000_0404);
    checks++; if (imm_src_o !== 3'b000) begin
      failures++; $display("FAIL imm_src_i got=%b exp=000", imm_src_o); end
    tick();
    checks++; if (alu_res_o !== 32'hF800_0000) begin
      failures++; $display("FAIL srai got=%h exp=F8000000", alu_res_o); end
    drive(32'h0041_5093, 32'h0, 32'h8000_0000, 32'h0, 32'h0000_0004);
    tick();
    checks++; if (alu_res_o !== 32'h0800_0000) begin
      failures++; $display("FAIL srli got=%h exp=08000000", alu_res_o); end
    // ADDI with imm bit 30 set must still add, not subtract
    drive(32'hC001_0093, 32'h0, 32'd10, 32'd99, 32'hFFFF_FC00);
    tick();
    checks++; if (alu_res_o !== 32'hFFFF_FC0A) begin
      failures++; $display("FAIL addi_neg got=%h exp=FFFFFC0A", alu_res_o); end
  endtask

  task automatic test_branch();
    drive(32'h0000_0063, 32'h100, 32'd3, 32'd3, 32'd8);
    checks++; if (imm_src_o !== 3'b010) begin
      failures++; $display("FAIL imm_src_b got=%b exp=010", imm_src_o); end
    tick();
    checks++; if (next_pc_src_o !== 1'b1 || alu_res_o !== 32'h108 || ru_wr_o !== 1'b0) begin
      failures++; $display("FAIL beq_taken got npc=%b res=%h ru=%b exp 1 00000108 0", next_pc_src_o, alu_res_o, ru_wr_o); end
    drive(32'h0000_0063, 32'h100, 32'd3, 32'd4, 32'd8);
    tick();
    checks++; if (next_pc_src_o !== 1'b0) begin
      failures++; $display("FAIL beq_not_taken got=%b exp=0", next_pc_src_o); end
    drive(32'h0000_1063, 32'h100, 32'd3, 32'd4, 32'd8);
    tick();
    checks++; if (next_pc_src_o !== 1'b1) begin
      failures++; $display("FAIL bne got=%b exp=1", next_pc_src_o); end
    drive(32'h0000_6063, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'd8);
    tick();
    checks++; if (next_pc_src_o !== 1'b0) begin
      failures++; $display("FAIL bltu got=%b exp=0", next_pc_src_o); end
    drive(32'h0000_4063, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'd8);
    tick();
    checks++; if (next_pc_src_o !== 1'b1) begin
      failures++; $display("FAIL blt got=%b exp=1", next_pc_src_o); end
    drive(32'h0000_7063, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'd8);
    tick();
    checks++; if (next_pc_src_o !== 1'b1) begin
      failures++; $display("FAIL bgeu got=%b exp=1", next_pc_src_o); end
    drive(32'h0000_2063, 32'h100, 32'd3, 32'd3, 32'd8);
    tick();
    checks++; if (next_pc_src_o !== 1'b0) begin
      failures++; $display("FAIL br_f3_010 got=%b exp=0", next_pc_src_o); end
  endtask

  task automatic test_jump();
    drive(32'h0000_006F, 32'h20, 32'd5, 32'd6, 32'h10);
    checks++; if (imm_src_o !== 3'b100) begin
      failures++; $display("FAIL imm_src_j got=%b exp=100", imm_src_o); end
    tick();
    checks++; if (next_pc_src_o !== 1'b1 || alu_res_o !== 32'h30 || ru_data_wr_src_o !== 2'b10 || ru_wr_o !== 1'b1) begin
      failures++; $display("FAIL jal got npc=%b res=%h wb=%b ru=%b exp 1 00000030 10 1", next_pc_src_o, alu_res_o, ru_data_wr_src_o, ru_wr_o); end
    drive(32'h0000_0067, 32'h20, 32'h1000, 32'h7, 32'h4);
    tick();
    checks++; if (next_pc_src_o !== 1'b1 || alu_res_o !== 32'h1004 || ru_data_wr_src_o !== 2'b10) begin
      failures++; $display("FAIL jalr got npc=%b res=%h wb=%b exp 1 00001004 10", next_pc_src_o, alu_res_o, ru_data_wr_src_o); end
  endtask

  task automatic test_mem();
    drive(32'h0000_2003, 32'h0, 32'h200, 32'h0, 32'h8);
    tick();
    checks++; if (dm_rd_o !== 1'b1 || ru_wr_o !== 1'b1 || ru_data_wr_src_o !== 2'b01 || dm_wr_o !== 1'b0 || alu_res_o !== 32'h208 || dm_ctrl_o !== 3'b010) begin
      failures++; $display("FAIL lw got dr=%b ru=%b wb=%b dw=%b res=%h ctl=%b exp 1 1 01 0 00000208 010",
        dm_rd_o, ru_wr_o, ru_data_wr_src_o, dm_wr_o, alu_res_o, dm_ctrl_o); end
    drive(32'h0000_2023, 32'h0, 32'h200, 32'h55, 32'hFFFF_FFFC);
    checks++; if (imm_src_o !== 3'b001) begin
      failures++; $display("FAIL imm_src_s got=%b exp=001", imm_src_o); end
    tick();
    checks++; if (dm_wr_o !== 1'b1 || ru_wr_o !== 1'b0 || dm_rd_o !== 1'b0 || alu_res_o !== 32'h1FC) begin
      failures++; $display("FAIL sw got dw=%b ru=%b dr=%b res=%h exp 1 0 0 000001FC", dm_wr_o, ru_wr_o, dm_rd_o, alu_res_o); end
  endtask

  task automatic test_upper();
    drive(32'h1234_50B7, 32'h400, 32'hAAAA_AAAA, 32'h0, 32'h1234_5000);
    checks++; if (imm_src_o !== 3'b011) begin
      failures++; $display("FAIL imm_src_u got=%b exp=011", imm_src_o); end
    tick();
    checks++; if (alu_res_o !== 32'h1234_5000 || ru_wr_o !== 1'b1) begin
      failures++; $display("FAIL lui got res=%h ru=%b exp 12345000 1", alu_res_o, ru_wr_o); end
    drive(32'h0000_1097, 32'h400, 32'hAAAA_AAAA, 32'h0, 32'h1000);
    tick();
    checks++; if (alu_res_o !== 32'h1400) begin
      failures++; $display("FAIL auipc got=%h exp=00001400", alu_res_o); end
  endtask

  task automatic test_illegal();
    // Follow a taken jump so stale redirect/write state would be visible.
    drive(32'h0000_006F, 32'h20, 32'd0, 32'd0, 32'h10);
    tick();
    drive(32'h0000_0000, 32'h20, 32'd1, 32'd1, 32'h10);
    tick();
    checks++; if (ru_wr_o !== 1'b0 || dm_wr_o !== 1'b0 || dm_rd_o !== 1'b0 || next_pc_src_o !== 1'b0) begin
      failures++; $display("FAIL opcode0_inert got ru=%b dw=%b dr=%b npc=%b exp 0 0 0 0", ru_wr_o, dm_wr_o, dm_rd_o, next_pc_src_o); end
  endtask

  task automatic test_back_to_back();
    drive(32'h0020_8033, 32'h0, 32'd100, 32'd23, 32'd0);
    tick();
    checks++; if (alu_res_o !== 32'd123) begin
      failures++; $display("FAIL b2b_first got=%h exp=0000007B", alu_res_o); end
    drive(32'h4020_8033, 32'h0, 32'd100, 32'd23, 32'd0);
    tick();
    checks++; if (alu_res_o !== 32'd77) begin
      failures++; $display("FAIL b2b_second got=%h exp=0000004D", alu_res_o); end
  endtask

  initial begin
    rst = 1'b1;
    inst_i = '0; pc_i = '0; rs1_data_i = '0; rs2_data_i = '0; imm_i = '0;
    test_reset();
    test_r_alu();
    test_i_alu();
    test_branch();
    test_jump();
    test_mem();
    test_upper();
    test_illegal();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
